dbg_cmd_responder: RTL
======================

# dbg_cmd_responder

Hardware debug-command responder for the Synapse316 debug link: it is the responder end of the byte protocol that a host or supervisor drives over the debug UART. It parses command frames from the UART receiver, performs peek/poke accesses on a 16-bit register-file bus, and returns response bytes through the UART transmitter. It sits between `uart_v2_rx`/`uart_v2_tx` and any register file addressed by `r_addr`. With it, the register file can be inspected and modified over the link without a running visor program.

## Interface
Parameters:
- `ADDR_WIDTH`, default 6: register address width; valid addresses are 0..2^ADDR_WIDTH-1.
- `TIMEOUT`, default 65535: number of idle sysclk cycles after which a partial frame is abandoned.

Ports:
- `sysclk` in 1: the single clock.
- `sysreset` in 1: reset, synchronous and active-high.
- `rx_byte` in 8: received byte; valid only while `rx_strobe` is high.
- `rx_strobe` in 1: one-cycle pulse per received byte.
- `tx_byte` out 8: byte to transmit.
- `tx_load` out 1: level request to the transmitter.
- `tx_busy` in 1: transmitter busy flag; may arrive asynchronously and must be 2-flop synchronized internally.
- `r_addr` out ADDR_WIDTH: register address.
- `r_data_in` in 16: register read data, combinational from `r_addr`.
- `r_read` out 1: one-cycle read pulse. It is needed for stack-type registers.
- `r_load` out 1: one-cycle write pulse.
- `r_load_data` out 16: write data.
- `busy` out 1: high whenever the state is not IDLE.
- `err_overrun` out 1: sticky flag; cleared only by reset.

## Operation
Frames (bytes in order):
- `0x57` 'W', A, H, L: write {H,L} to register A, then respond `0x4B` 'K'.
- `0x52` 'R', A: read register A, then respond H and then L (MSB first).
- `0x50` 'P': ping; respond `0x4B`.
- Any other first byte: respond `0x3F` '?'; no bus access.
- Address byte validity: if A[7:ADDR_WIDTH] is nonzero, the responder still collects the remaining frame bytes, then responds `0x3F` with no bus access.

States:
- IDLE to GET_ADDR on 'W' or 'R'.
- IDLE to SEND on 'P' or an unknown opcode.
- GET_ADDR to GET_HI (on 'W') or READ (on 'R').
- GET_HI to GET_LO.
- GET_LO to WRITE.
- WRITE and READ to SEND.
- SEND covers one or two response bytes, then IDLE.
- State advances only on `rx_strobe` in the GET_* states.

Transmit handshake, per byte:
- Wait in SEND until synchronized `tx_busy` is 0.
- Drive `tx_byte` and raise `tx_load`.
- Hold `tx_load` until synchronized `tx_busy` reads 1, then drop it.
- The next byte, or the return to IDLE, waits for synchronized `tx_busy` to read 0 again.

Boundary conditions:
- Overrun: an `rx_strobe` in READ, WRITE or SEND drops that byte and sets `err_overrun`. The frame in progress is not disturbed.
- Timeout: the idle counter resets on every accepted byte. When it reaches TIMEOUT in any GET_* state, return to IDLE with no response and no bus access.
- The counter is 16 bits and saturates.
- Reset in any state returns to IDLE with all outputs zeroed. A `tx_load` in flight is dropped.

## Timing
Reset values:
- All outputs are 0: `tx_byte`, `tx_load`, `r_addr`, `r_read`, `r_load`, `r_load_data`, `busy`, `err_overrun`.
- State is IDLE and the capture registers are 0.

Latencies (cycle N is the cycle in which `rx_strobe` carries the named byte):
- Write: L strobed in cycle N gives `r_load`=1 with stable `r_addr`/`r_load_data` in cycle N+1 only.
- Read: A strobed in cycle N gives `r_read`=1 in cycle N+1. `r_data_in` is captured at the end of cycle N+1. `tx_load` rises no earlier than N+2.
- `r_addr` and `r_load_data` hold their last values between accesses.
- Byte acceptance: in the GET_* states, one byte is accepted per `rx_strobe`, including back-to-back strobes on consecutive cycles.

## Test plan
- Reset, then 'P' (0x50) -> exactly one tx byte 0x4B; no `r_read` or `r_load` pulses; `busy` returns to 0.
- 'W',0x05,0x12,0x34 -> single-cycle `r_load`, `r_addr`=5, `r_load_data`=0x1234, then tx 0x4B.
- 'R',0x05 with a register model returning 0xBEEF -> single-cycle `r_read` at `r_addr`=5, then tx 0xBE followed by 0xEF, each gated by the `tx_busy` handshake.
- Error frames:
  - 'R',0x40 with ADDR_WIDTH=6 -> tx 0x3F, no `r_read`.
  - Opcode 0x00 -> tx 0x3F.
- 'W',0x01 followed by TIMEOUT idle cycles, then 'P' -> no write and no response for the partial frame; 'P' answered with 0x4B.
- Extra byte strobed during SEND -> `err_overrun`=1, response unchanged. Then assert `sysreset` mid-SEND -> all outputs 0 and `err_overrun` cleared on the next cycle.

Source files
------------

// File: rtl/dbg_cmd_responder.sv
// dbg_cmd_responder: the responder end of the Synapse316 debug byte protocol.
// It parses command frames from the UART receiver and performs peek/poke
// accesses on a 16-bit register-file bus. Response bytes go back through the
// UART transmitter.
//   Frames:  'W' A H L -> write {H,L} to A, reply 'K'
//            'R' A     -> read A, reply H then L
//            'P'       -> reply 'K'
//            other     -> reply '?'
//   An address with bits above ADDR_WIDTH set is answered with '?'.
//   No bus access takes place for such an address.
// Ports:
//   sysclk, sysreset           clock, synchronous active-high reset
//   rx_byte, rx_strobe         byte from UART rx, one-cycle strobe per byte
//   tx_byte, tx_load, tx_busy  byte and level request to UART tx, tx busy (async)
//   r_addr, r_data_in          register address, combinational read data
//   r_read, r_load             one-cycle read / write pulses
//   r_load_data                write data
//   busy                       responder not idle
//   err_overrun                sticky: a byte arrived while the responder could not take it
module dbg_cmd_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  sysclk,
  input  logic                  sysreset,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_strobe,
  output logic [7:0]            tx_byte,
  output logic                  tx_load,
  input  logic                  tx_busy,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [15:0]           r_data_in,
  output logic                  r_read,
  output logic                  r_load,
  output logic [15:0]           r_load_data,
  output logic                  busy,
  output logic                  err_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_HI, S_GET_LO, S_WRITE, S_READ, S_SEND
  } state_t;

  // Per-byte transmit handshake phases inside S_SEND.
  typedef enum logic [1:0] {PH_WAIT, PH_HOLD, PH_DRAIN} ph_t;

  // Response: first byte in data[15:8], second in data[7:0] when two is set.
  typedef struct packed {
    logic [15:0] data;
    logic        two;
  } resp_t;

  localparam logic [7:0]  OP_W   = 8'h57;
  localparam logic [7:0]  OP_R   = 8'h52;
  localparam logic [7:0]  OP_P   = 8'h50;
  localparam logic [7:0]  RSP_K  = 8'h4B;
  localparam logic [7:0]  RSP_Q  = 8'h3F;
  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  state_t      state, state_nxt;
  ph_t         ph;
  resp_t       resp;
  logic        idx;
  logic [1:0]  busy_sync;
  logic        busy_s;
  logic [15:0] cnt;
  logic        is_wr;
  logic [7:0]  addr_q;
  logic        addr_ok_q;
  logic [7:0]  hi_q;
  logic        in_get;
  logic        timeout;
  logic        send_done;
  logic [7:0]  cur_byte;

  function automatic logic addr_ok(input logic [7:0] a);
    return (a >> ADDR_WIDTH) == 8'd0;
  endfunction

  assign busy_s   = busy_sync[1];
  assign busy     = (state != S_IDLE);
  assign cur_byte = idx ? resp.data[7:0] : resp.data[15:8];

  always_comb begin
    in_get    = (state == S_GET_ADDR) || (state == S_GET_HI) || (state == S_GET_LO);
    // An arriving byte wins over an expiring count on the same cycle.
    timeout   = in_get && !rx_strobe && (cnt >= TO_CNT);
    send_done = (ph == PH_DRAIN) && !busy_s && !(resp.two && !idx);
    state_nxt = state;
    case (state)
      S_IDLE:
        if (rx_strobe)
          state_nxt = (rx_byte == OP_W || rx_byte == OP_R) ? S_GET_ADDR : S_SEND;
      S_GET_ADDR:
        if (rx_strobe)    state_nxt = is_wr ? S_GET_HI : S_READ;
        else if (timeout) state_nxt = S_IDLE;
      S_GET_HI:
        if (rx_strobe)    state_nxt = S_GET_LO;
        else if (timeout) state_nxt = S_IDLE;
      S_GET_LO:
        if (rx_strobe)    state_nxt = S_WRITE;
        else if (timeout) state_nxt = S_IDLE;
      S_WRITE:  state_nxt = S_SEND;
      S_READ:   state_nxt = S_SEND;
      S_SEND:   if (send_done) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      busy_sync   <= '0;
      cnt         <= '0;
      ph          <= PH_WAIT;
      resp        <= '0;
      idx         <= 1'b0;
      is_wr       <= 1'b0;
      addr_q      <= '0;
      addr_ok_q   <= 1'b0;
      hi_q        <= '0;
      tx_byte     <= '0;
      tx_load     <= 1'b0;
      r_addr      <= '0;
      r_read      <= 1'b0;
      r_load      <= 1'b0;
      r_load_data <= '0;
      err_overrun <= 1'b0;
    end else begin
      busy_sync <= {busy_sync[0], tx_busy};
      r_read    <= 1'b0;
      r_load    <= 1'b0;

      // Idle counter: cleared on accepted bytes and outside the GET_* states.
      if (in_get && !rx_strobe) begin
        if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end else begin
        cnt <= '0;
      end

      if (rx_strobe && (state == S_READ || state == S_WRITE || state == S_SEND))
        err_overrun <= 1'b1;

      case (state)
        S_IDLE: if (rx_strobe) begin
          is_wr     <= (rx_byte == OP_W);
          resp.data <= {(rx_byte == OP_P) ? RSP_K : RSP_Q, 8'h00};
          resp.two  <= 1'b0;
          idx       <= 1'b0;
          ph        <= PH_WAIT;
        end
        S_GET_ADDR: if (rx_strobe) begin
          addr_q    <= rx_byte;
          addr_ok_q <= addr_ok(rx_byte);
          // Read pulse lands in the cycle after A, with r_addr already valid.
          if (!is_wr && addr_ok(rx_byte)) begin
            r_read <= 1'b1;
            r_addr <= rx_byte[ADDR_WIDTH-1:0];
          end
        end
        S_GET_HI: if (rx_strobe) hi_q <= rx_byte;
        S_GET_LO: if (rx_strobe && addr_ok_q) begin
          r_load      <= 1'b1;
          r_addr      <= addr_q[ADDR_WIDTH-1:0];
          r_load_data <= {hi_q, rx_byte};
        end
        S_WRITE: begin
          resp.data <= {addr_ok_q ? RSP_K : RSP_Q, 8'h00};
          resp.two  <= 1'b0;
        end
        S_READ: begin
          // r_addr still holds A from the read pulse cycle.
          resp.data <= addr_ok_q ? r_data_in : {RSP_Q, 8'h00};
          resp.two  <= addr_ok_q;
        end
        S_SEND: case (ph)
          PH_WAIT: if (!busy_s) begin
            tx_byte <= cur_byte;
            tx_load <= 1'b1;
            ph      <= PH_HOLD;
          end
          PH_HOLD: if (busy_s) begin
            tx_load <= 1'b0;
            ph      <= PH_DRAIN;
          end
          PH_DRAIN: if (!busy_s) begin
            ph <= PH_WAIT;
            if (resp.two && !idx) idx <= 1'b1;
          end
          default: ph <= PH_WAIT;
        endcase
        default: ;
      endcase
    end
  end

endmodule
